// File: rtl/mux2_arb.sv
// mux2_arb: two-source burst-aware stream merger with one output register.
// Define MUX2_ARB_ROUND_ROBIN_EN for round-robin idle arbitration.
module mux2_arb #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic                  last0_i,
  input  logic                  valid0_i,
  output logic                  ready0_o,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic                  last1_i,
  input  logic                  valid1_i,
  output logic                  ready1_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  src_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BURST0 = 2'd1;
  localparam logic [1:0] BURST1 = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;
  logic                  src_q;

  logic                  load;
  logic                  gnt_vld;
  logic                  gnt_idx;
  logic                  acc;
  logic                  acc_last;
  logic [DATA_WIDTH-1:0] acc_data;

`ifdef MUX2_ARB_ROUND_ROBIN_EN
  // Index of the source granted at the last idle acceptance.
  logic rr_q, rr_d;
`endif

  assign load = !valid_q || ready_i;

  // Grant: open arbitration in IDLE, locked to the owner mid-burst.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid0_i && valid1_i) begin
          gnt_vld = 1'b1;
`ifdef MUX2_ARB_ROUND_ROBIN_EN
          gnt_idx = ~rr_q;
`else
          gnt_idx = 1'b0;
`endif
        end else if (valid0_i) begin
          gnt_vld = 1'b1;
          gnt_idx = 1'b0;
        end else if (valid1_i) begin
          gnt_vld = 1'b1;
          gnt_idx = 1'b1;
        end
      end
      BURST0: begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end
      BURST1: begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
      end
    endcase
  end

  assign ready0_o = !reset_i && load && gnt_vld && !gnt_idx;
  assign ready1_o = !reset_i && load && gnt_vld && gnt_idx;

  assign acc      = gnt_idx ? (ready1_o && valid1_i)
                            : (ready0_o && valid0_i);
  assign acc_last = gnt_idx ? last1_i : last0_i;
  assign acc_data = gnt_idx ? data1_i : data0_i;

  // Burst tracking: a non-last accepted beat locks its source.
  always_comb begin
    state_d = state_q;
    if (acc) begin
      if (acc_last)     state_d = IDLE;
      else if (gnt_idx) state_d = BURST1;
      else              state_d = BURST0;
    end
  end

`ifdef MUX2_ARB_ROUND_ROBIN_EN
  // Pointer moves only on acceptances made from IDLE.
  always_comb begin
    rr_d = rr_q;
    if (acc && state_q == IDLE) rr_d = gnt_idx;
  end

  // Pointer register; reset favours source 0 first.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) rr_q <= 1'b1;
    else         rr_q <= rr_d;
  end
`endif

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Output register: refill on load, hold while the sink stalls.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= 1'b0;
    end else if (load) begin
      valid_q <= acc;
      if (acc) begin
        data_q <= acc_data;
        last_q <= acc_last;
        src_q  <= gnt_idx;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign src_o   = src_q;

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of each data beat.
REQ-002 SHALL have port clock_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have ports data0_i, last0_i, valid0_i, all inputs of widths DATA_WIDTH/1/1: source 0 beat, end-of-burst flag and valid.
REQ-005 SHALL have port ready0_o, output, 1, source 0 beat accepted this cycle when high with valid0_i.
REQ-006 SHALL have ports data1_i, last1_i, valid1_i, all inputs of widths DATA_WIDTH/1/1, and ready1_o, output, 1: source 1, same meanings.
REQ-007 SHALL have ports data_o, last_o, valid_o, all outputs of widths DATA_WIDTH/1/1: registered merged stream.
REQ-008 SHALL have port ready_i, input, 1, sink accepts the output beat when high with valid_o.
REQ-009 SHALL have port src_o, output, 1, the index of the source that produced the current output beat.

Function
REQ-010 SHALL hold a single output register; load = !valid_o || ready_i.
REQ-011 SHALL assert readyN_o combinationally only when load is high and source N holds the grant; the other ready SHALL be 0.
REQ-012 SHALL accept at most one beat per cycle; an accepted beat SHALL appear on data_o/last_o/src_o with valid_o=1 on the next cycle (latency 1).
REQ-013 SHALL clear valid_o when load is high and no beat is accepted.
REQ-014 SHALL hold data_o/last_o/src_o/valid_o stable while valid_o=1 and ready_i=0.
REQ-015 SHALL sustain one beat per cycle when ready_i is held high.
REQ-016 SHALL implement states IDLE, BURST0 and BURST1.
REQ-017 In IDLE, SHALL grant per the arbitration policy (REQ-026/027) among the valid sources; no valid source means no grant.
REQ-018 In IDLE, an accepted beat from source N with lastN_i=0 SHALL move the state to BURSTN; with lastN_i=1 the state SHALL remain IDLE.
REQ-019 In BURSTN, SHALL grant only source N, even when the other source is valid and source N is not.
REQ-020 In BURSTN, SHALL return to IDLE on acceptance of a source N beat with lastN_i=1.
REQ-021 A single-beat burst (last=1 on the first beat) SHALL not leave IDLE.
REQ-022 SHALL never drop, duplicate or reorder beats within a source.
REQ-023 SHALL not allow interleaving of two bursts on the output.
REQ-024 SHALL let a sink stall (ready_i=0) of any length mid-burst hold the burst state with no state change.

Reset
REQ-025 On reset_i=1, SHALL immediately force: valid_o=0, data_o=0, last_o=0, src_o=0, state=IDLE, round-robin pointer=1 (source 0 wins first); ready0_o/ready1_o=0 while in reset. Reset mid-burst SHALL abandon the burst; the first post-reset beat is arbitrated from IDLE.

Configuration
REQ-026 With macro MUX2_ARB_ROUND_ROBIN_EN defined, IDLE arbitration SHALL be round-robin: when both are valid, grant the source not granted at the last IDLE acceptance; the pointer updates only on IDLE acceptance.
REQ-027 Without MUX2_ARB_ROUND_ROBIN_EN, IDLE arbitration SHALL be fixed priority, source 0 over source 1; the pointer register SHALL not exist.

Verification
REQ-028 Reset: assert reset_i mid-burst with valid_o=1 -> valid_o=0 and ready0_o=ready1_o=0 without a clock edge; after release, both valid -> source 0 granted.
REQ-029 Single beats, both sources always valid, last=1, ready_i=1, round-robin build, data0=0xA000_000n, data1=0xB000_000n -> output alternates A,B,A,B with src_o 0,1,0,1 at one beat/cycle.
REQ-030 Same stimulus as REQ-029, fixed-priority build -> only source 0 beats appear; ready1_o stays 0.
REQ-031 Burst lock: source 1 sends 3 beats (last on the 3rd) while source 0 is valid throughout -> outputs are src 1 x3 contiguous, then source 0; source 1 gaps mid-burst produce output bubbles, not source 0 beats.
REQ-032 Back-pressure: ready_i low for 5 cycles with valid_o=1 data 0x1234_5678 -> data_o/src_o/last_o are stable, both readies are 0, and nothing is lost after release.
REQ-033 Random valid/ready/last, 10k cycles -> per-source scoreboard order is exact, no output interleaving inside bursts, and no beat accepted while load=0.
